// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
interface execute_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10
);
  logic              PCSrc;
  logic [1:0]        ALUOp;
  logic              RegDst;
  logic              ALUSrc;
  logic              Branch;
  logic              MemRead;
  logic              MemWrite;
  logic              MemToReg;
  logic              RegWrite;
  logic [DATA_W-1:0] regA;
  logic [DATA_W-1:0] regB;
  logic [DATA_W-1:0] signExtend;
  logic [PC_W-1:0]   PcCount;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [1:0]        forwardA;
  logic [1:0]        forwardB;
  logic [DATA_W-1:0] exMemResult;
  logic [DATA_W-1:0] memWbResult;

  logic [DATA_W-1:0] aluResultOut;
  logic [DATA_W-1:0] writeDataOut;
  logic [4:0]        writeRegOut;
  logic              BranchOut;
  logic              MemReadOut;
  logic              MemWriteOut;
  logic              MemToRegOut;
  logic              RegWriteOut;
  logic              zeroOut;
  logic [PC_W-1:0]   branchTargetOut;
  logic              stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output PCSrc, ALUOp, RegDst, ALUSrc, Branch, MemRead, MemWrite, MemToReg, RegWrite,
           regA, regB, signExtend, PcCount, rt, rd, forwardA, forwardB, exMemResult, memWbResult,
    input  aluResultOut, writeDataOut, writeRegOut, BranchOut, MemReadOut, MemWriteOut,
           MemToRegOut, RegWriteOut, zeroOut, branchTargetOut, stall, hi, lo
  );

  modport slave (
    input  PCSrc, ALUOp, RegDst, ALUSrc, Branch, MemRead, MemWrite, MemToReg, RegWrite,
           regA, regB, signExtend, PcCount, rt, rd, forwardA, forwardB, exMemResult, memWbResult,
    output aluResultOut, writeDataOut, writeRegOut, BranchOut, MemReadOut, MemWriteOut,
           MemToRegOut, RegWriteOut, zeroOut, branchTargetOut, stall, hi, lo
  );
endinterface

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage with forwarding, ALU, shift-add MULTU and EX/MEM register
// All state updates on the falling clock edge.
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10
) (
  input logic             clk,
  input logic             reset,
  execute_stage_if.slave  ex
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state;
  state_t              stateNext;
  logic [4:0]          counter;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] addend;

  logic [5:0]          funct;
  logic [4:0]          shamt;
  logic [DATA_W-1:0]   fwdA;
  logic [DATA_W-1:0]   fwdB;
  logic [DATA_W-1:0]   opB;
  logic [DATA_W-1:0]   aluResult;
  logic                isMultu;
  logic                startMul;
  logic                mulLast;
  logic                loadBubble;

  assign funct   = ex.signExtend[5:0];
  assign shamt   = ex.signExtend[10:6];
  assign isMultu = (ex.ALUOp == 2'b10) && (funct == 6'h19);
  assign opB     = ex.ALUSrc ? ex.signExtend : fwdB;
  assign addend  = mplier[0] ? mcand : '0;
  assign ex.stall = (state == MUL);

  // Select 11 behaves like 00 (no forwarding).
  always_comb begin
    fwdA = ex.regA;
    fwdB = ex.regB;
    case (ex.forwardA)
      2'b10:   fwdA = ex.exMemResult;
      2'b01:   fwdA = ex.memWbResult;
      default: fwdA = ex.regA;
    endcase
    case (ex.forwardB)
      2'b10:   fwdB = ex.exMemResult;
      2'b01:   fwdB = ex.memWbResult;
      default: fwdB = ex.regB;
    endcase
  end

  always_comb begin
    aluResult = '0;
    case (ex.ALUOp)
      2'b00: aluResult = fwdA + opB;
      2'b01: aluResult = fwdA - opB;
      2'b11: aluResult = fwdA | opB;
      default: begin
        case (funct)
          6'h20:   aluResult = fwdA + opB;
          6'h22:   aluResult = fwdA - opB;
          6'h24:   aluResult = fwdA & opB;
          6'h25:   aluResult = fwdA | opB;
          6'h2A:   aluResult = ($signed(fwdA) < $signed(opB)) ? DATA_W'(1) : '0;
          6'h00:   aluResult = opB << shamt;
          6'h02:   aluResult = opB >> shamt;
          6'h10:   aluResult = ex.hi;
          6'h12:   aluResult = ex.lo;
          default: aluResult = '0;
        endcase
      end
    endcase
  end

  always_comb begin
    stateNext  = state;
    startMul   = 1'b0;
    mulLast    = 1'b0;
    loadBubble = 1'b0;
    case (state)
      IDLE: begin
        if (ex.PCSrc) begin
          loadBubble = 1'b1;
        end else if (isMultu) begin
          startMul   = 1'b1;
          loadBubble = 1'b1;
          stateNext  = MUL;
        end
      end
      MUL: begin
        loadBubble = 1'b1;
        if (ex.PCSrc) begin
          stateNext = IDLE;
        end else if (counter == 5'd31) begin
          mulLast   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        loadBubble = 1'b1;
        stateNext  = IDLE;
      end
      default: begin
        loadBubble = 1'b1;
        stateNext  = IDLE;
      end
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Multiplier: one partial product per edge; an abort leaves HI/LO untouched.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      ex.hi   <= '0;
      ex.lo   <= '0;
    end else if (startMul) begin
      counter <= '0;
      mcand   <= {{DATA_W{1'b0}}, fwdA};
      mplier  <= opB;
      prod    <= '0;
    end else if (state == MUL && !ex.PCSrc) begin
      if (mulLast) begin
        {ex.hi, ex.lo} <= prod + addend;
      end else begin
        prod    <= prod + addend;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        counter <= counter + 5'd1;
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset || loadBubble) begin
      ex.aluResultOut    <= '0;
      ex.writeDataOut    <= '0;
      ex.writeRegOut     <= '0;
      ex.BranchOut       <= 1'b0;
      ex.MemReadOut      <= 1'b0;
      ex.MemWriteOut     <= 1'b0;
      ex.MemToRegOut     <= 1'b0;
      ex.RegWriteOut     <= 1'b0;
      ex.zeroOut         <= 1'b0;
      ex.branchTargetOut <= '0;
    end else begin
      ex.aluResultOut    <= aluResult;
      ex.writeDataOut    <= fwdB;
      ex.writeRegOut     <= ex.RegDst ? ex.rd : ex.rt;
      ex.BranchOut       <= ex.Branch;
      ex.MemReadOut      <= ex.MemRead;
      ex.MemWriteOut     <= ex.MemWrite;
      ex.MemToRegOut     <= ex.MemToReg;
      ex.RegWriteOut     <= ex.RegWrite;
      ex.zeroOut         <= (aluResult == '0);
      ex.branchTargetOut <= ex.PcCount + ex.signExtend[PC_W-1:0];
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;
  logic clk;
  logic reset;
  int   passCount;
  int   checkCount;

  execute_stage_if #(.DATA_W(32), .PC_W(10)) bus ();

  execute_stage #(.DATA_W(32), .PC_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registers move on negedge; drive and sample on the following posedge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passCount++;
  endtask

  task automatic clearInputs();
    bus.PCSrc = 0; bus.ALUOp = 2'b00; bus.RegDst = 0; bus.ALUSrc = 0;
    bus.Branch = 0; bus.MemRead = 0; bus.MemWrite = 0; bus.MemToReg = 0; bus.RegWrite = 0;
    bus.regA = 0; bus.regB = 0; bus.signExtend = 0; bus.PcCount = 0;
    bus.rt = 0; bus.rd = 0; bus.forwardA = 2'b00; bus.forwardB = 2'b00;
    bus.exMemResult = 0; bus.memWbResult = 0;
  endtask

  task automatic startMultu(input logic [31:0] a, input logic [31:0] b);
    clearInputs();
    bus.ALUOp = 2'b10; bus.signExtend = 32'h19; bus.regA = a; bus.regB = b; bus.RegWrite = 1;
  endtask

  task automatic test_reset();
    #1;
    check("reset_alu", bus.aluResultOut, 32'h0);
    check("reset_stall", {31'b0, bus.stall}, 32'h0);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    @(posedge clk);
    reset = 1;
  endtask

  task automatic test_rtype();
    clearInputs();
    bus.ALUOp = 2'b10; bus.signExtend = 32'h20; bus.regA = 7; bus.regB = 5;
    bus.RegDst = 1; bus.rd = 3; bus.rt = 9; bus.RegWrite = 1;
    step();
    check("add_result", bus.aluResultOut, 32'd12);
    check("add_wreg", {27'b0, bus.writeRegOut}, 32'd3);
    check("add_zero", {31'b0, bus.zeroOut}, 32'd0);
    check("add_regwrite", {31'b0, bus.RegWriteOut}, 32'd1);
    check("add_wdata", bus.writeDataOut, 32'd5);

    bus.signExtend = 32'h2A; bus.regA = 32'hFFFFFFFF; bus.regB = 1; bus.RegDst = 0; bus.rt = 6;
    step();
    check("slt_result", bus.aluResultOut, 32'd1);
    check("slt_wreg_rt", {27'b0, bus.writeRegOut}, 32'd6);

    bus.signExtend = 32'h22; bus.regA = 9; bus.regB = 9;
    step();
    check("sub_result", bus.aluResultOut, 32'd0);
    check("sub_zero", {31'b0, bus.zeroOut}, 32'd1);

    bus.signExtend = 32'h24; bus.regA = 32'hF0; bus.regB = 32'h3C;
    step();
    check("and_result", bus.aluResultOut, 32'h30);

    bus.signExtend = (32'd4 << 6) | 32'h00; bus.regB = 1;
    step();
    check("sll_result", bus.aluResultOut, 32'd16);

    bus.signExtend = (32'd3 << 6) | 32'h02; bus.regB = 32'h80;
    step();
    check("srl_result", bus.aluResultOut, 32'h10);

    bus.signExtend = 32'h3F; bus.regA = 5; bus.regB = 6;
    step();
    check("badfunct_result", bus.aluResultOut, 32'd0);
  endtask

  task automatic test_forward();
    clearInputs();
    bus.forwardA = 2'b10; bus.exMemResult = 100; bus.regA = 1;
    bus.ALUSrc = 1; bus.signExtend = 4; bus.PcCount = 5; bus.MemWrite = 1; bus.Branch = 1;
    step();
    check("fwdA_exmem", bus.aluResultOut, 32'd104);
    check("fwd_memwrite", {31'b0, bus.MemWriteOut}, 32'd1);
    check("fwd_branch_target", {22'b0, bus.branchTargetOut}, 32'd9);

    clearInputs();
    bus.ALUOp = 2'b11; bus.forwardB = 2'b01; bus.memWbResult = 32'h55; bus.regB = 2; bus.regA = 32'h100;
    step();
    check("fwdB_memwb_or", bus.aluResultOut, 32'h155);
    check("fwdB_store_data", bus.writeDataOut, 32'h55);

    clearInputs();
    bus.ALUOp = 2'b01; bus.forwardA = 2'b11; bus.forwardB = 2'b11;
    bus.regA = 3; bus.regB = 4; bus.exMemResult = 77; bus.memWbResult = 88;
    step();
    check("fwd11_sub_wrap", bus.aluResultOut, 32'hFFFFFFFF);
  endtask

  task automatic test_multu();
    int cnt;
    startMultu(32'hFFFFFFFF, 32'd2);
    step();
    check("mul_bubble", bus.aluResultOut, 32'h0);
    cnt = bus.stall ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.stall) break;
      step();
      if (bus.stall) cnt++;
    end
    check("mul_stall_cycles", cnt, 32'd32);
    check("mul_hi", bus.hi, 32'h1);
    check("mul_lo", bus.lo, 32'hFFFFFFFE);
    step();
    check("mul_consumed_regwrite", {31'b0, bus.RegWriteOut}, 32'd0);
    check("mul_done_stall", {31'b0, bus.stall}, 32'd0);
    clearInputs();
    bus.ALUOp = 2'b10; bus.signExtend = 32'h12;
    step();
    check("mflo_after_mul", bus.aluResultOut, 32'hFFFFFFFE);
    bus.signExtend = 32'h10;
    step();
    check("mfhi_after_mul", bus.aluResultOut, 32'h1);
  endtask

  task automatic test_abort();
    startMultu(32'd3, 32'd5);
    for (int i = 0; i < 10; i++) step();
    check("abort_stall_before", {31'b0, bus.stall}, 32'd1);
    bus.PCSrc = 1;
    step();
    check("abort_stall_after", {31'b0, bus.stall}, 32'd0);
    check("abort_hi", bus.hi, 32'h1);
    check("abort_lo", bus.lo, 32'hFFFFFFFE);
    check("abort_bubble", {31'b0, bus.RegWriteOut}, 32'd0);
    clearInputs();
    bus.ALUOp = 2'b10; bus.signExtend = 32'h20; bus.regA = 1; bus.regB = 1; bus.PCSrc = 1;
    step();
    check("pcsrc_flush_idle", bus.aluResultOut, 32'd0);
    clearInputs();
  endtask

  task automatic test_reset_mid_mul();
    startMultu(32'd7, 32'd7);
    step();
    step();
    step();
    #2 reset = 0;
    #1;
    check("rst_mid_stall", {31'b0, bus.stall}, 32'd0);
    check("rst_mid_hi", bus.hi, 32'h0);
    check("rst_mid_lo", bus.lo, 32'h0);
    check("rst_mid_alu", bus.aluResultOut, 32'h0);
    clearInputs();
    @(posedge clk);
    reset = 1;
  endtask

  task automatic test_branch_wrap();
    clearInputs();
    bus.PcCount = 10'h3FF; bus.signExtend = 2; bus.Branch = 1;
    step();
    check("branch_wrap_target", {22'b0, bus.branchTargetOut}, 32'h001);
    check("branch_out", {31'b0, bus.BranchOut}, 32'd1);
  endtask

  initial begin
    passCount = 0;
    checkCount = 0;
    reset = 0;
    clearInputs();
    test_reset();
    test_rtype();
    test_forward();
    test_multu();
    test_abort();
    test_reset_mid_mul();
    test_branch_wrap();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
